// File: rtl/alarm_pkg.sv
// ============================================================================
// Module  : alarm_pkg
// Brief   : Shared types and constants for the alarm-ring controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

    localparam int TIME_W = 16;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RINGING = 3'd2,
        ST_SNOOZE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_sequencer_if.sv
// ============================================================================
// Module  : alarm_sequencer_if
// Brief   : Time/button inputs and sounder/status outputs of the ring controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface alarm_sequencer_if;
    import alarm_pkg::*;

    logic              one_second;
    logic [TIME_W-1:0] alarm_time;
    logic [TIME_W-1:0] current_time;
    logic              alarm_on;
    logic              stop_button;
    logic              snooze_button;
    logic              sound_alarm;
    logic              snoozing;
    logic [3:0]        snooze_left;

    modport master (
        output one_second, alarm_time, current_time, alarm_on,
               stop_button, snooze_button,
        input  sound_alarm, snoozing, snooze_left
    );

    modport slave (
        input  one_second, alarm_time, current_time, alarm_on,
               stop_button, snooze_button,
        output sound_alarm, snoozing, snooze_left
    );

endinterface

`default_nettype wire

// File: rtl/alarm_sequencer_sec_timer.sv
// ============================================================================
// Module  : sec_timer
// Brief   : Clearable seconds counter with a terminal-count pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_timer #(
    parameter int WIDTH = 9
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic             tick,
    input  wire logic [WIDTH:0]   terminal,
    output logic      [WIDTH-1:0] count,
    output logic                  done
);

    // Terminal is one bit wider so a power-of-two terminal still fits.
    assign done = tick && ({1'b0, count} == (terminal - 1'b1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alarm_sequencer.sv
// ============================================================================
// Module  : alarm_sequencer
// Brief   : Alarm ring/snooze/stop/timeout sequencer. Define ALARM_BEEP_EN
//           for a 1 s on / 1 s off sounder pattern while ringing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SECS       = 300,
    parameter int RING_TIMEOUT_SECS = 60,
    parameter int MAX_SNOOZES       = 3
) (
    input  wire logic         clock,
    input  wire logic         reset,
    alarm_sequencer_if.slave  bus
);

    localparam int             CNT_W       = $clog2(max_int(SNOOZE_SECS, RING_TIMEOUT_SECS));
    localparam logic [CNT_W:0] SNOOZE_TERM = (CNT_W + 1)'(SNOOZE_SECS);
    localparam logic [CNT_W:0] RING_TERM   = (CNT_W + 1)'(RING_TIMEOUT_SECS);
    localparam logic [3:0]     MAX_SN      = 4'(MAX_SNOOZES);

    state_t           state;
    state_t           next_state;
    logic [3:0]       snooze_cnt;
    logic [3:0]       snooze_next;
    logic             match;
    logic             timer_tick;
    logic             timer_clear;
    logic             sec_done;
    logic [CNT_W:0]   terminal;
    logic [CNT_W-1:0] unused_sec_count;

    assign match       = (bus.current_time == bus.alarm_time);
    assign timer_tick  = bus.one_second && ((state == ST_RINGING) || (state == ST_SNOOZE));
    assign timer_clear = (next_state != state);
    assign terminal    = (state == ST_SNOOZE) ? SNOOZE_TERM : RING_TERM;

    sec_timer #(
        .WIDTH (CNT_W)
    ) u_sec_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear),
        .tick     (timer_tick),
        .terminal (terminal),
        .count    (unused_sec_count),
        .done     (sec_done)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.alarm_on) next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (!bus.alarm_on) next_state = ST_IDLE;
                else if (match)    next_state = ST_RINGING;
            end
            ST_RINGING: begin
                if (!bus.alarm_on)                                  next_state = ST_IDLE;
                else if (bus.stop_button)                           next_state = ST_DONE;
                else if (bus.snooze_button && (snooze_cnt < MAX_SN)) next_state = ST_SNOOZE;
                else if (sec_done)                                  next_state = ST_DONE;
            end
            ST_SNOOZE: begin
                if (!bus.alarm_on)        next_state = ST_IDLE;
                else if (bus.stop_button) next_state = ST_DONE;
                else if (sec_done)        next_state = ST_RINGING;
            end
            ST_DONE: begin
                // Held here until the minute changes so the same match cannot re-trigger.
                if (!bus.alarm_on) next_state = ST_IDLE;
                else if (!match)   next_state = ST_ARMED;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        snooze_next = snooze_cnt;
        if ((next_state == ST_IDLE) || (next_state == ST_ARMED)) begin
            snooze_next = '0;
        end else if ((state == ST_RINGING) && (next_state == ST_SNOOZE)) begin
            snooze_next = snooze_cnt + 1'b1;
        end
    end

`ifdef ALARM_BEEP_EN
    logic beep_phase;
    logic beep_next;

    always_comb begin
        beep_next = beep_phase;
        if ((next_state == ST_RINGING) && (state != ST_RINGING)) begin
            beep_next = 1'b1;
        end else if ((state == ST_RINGING) && bus.one_second) begin
            beep_next = ~beep_phase;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            snooze_cnt      <= '0;
            bus.sound_alarm <= 1'b0;
            bus.snoozing    <= 1'b0;
            bus.snooze_left <= MAX_SN;
`ifdef ALARM_BEEP_EN
            beep_phase      <= 1'b0;
`endif
        end else begin
            state           <= next_state;
            snooze_cnt      <= snooze_next;
            bus.snoozing    <= (next_state == ST_SNOOZE);
            bus.snooze_left <= MAX_SN - snooze_next;
`ifdef ALARM_BEEP_EN
            beep_phase      <= beep_next;
            bus.sound_alarm <= (next_state == ST_RINGING) && beep_next;
`else
            bus.sound_alarm <= (next_state == ST_RINGING);
`endif
        end
    end

endmodule

`default_nettype wire
